// File: rtl/io_bus_arbiter_if.sv
// Bus bundle between the requesters, the arbiter and the downstream I/O slave port.
// The arbiter uses the master view; requesters and downstream slave models use the slave view.
interface io_bus_arbiter_if #(
   parameter int NREQ = 4
);
   logic [NREQ-1:0]      req_cyc_i;
   logic [NREQ-1:0]      req_stb_i;
   logic [NREQ-1:0]      req_we_i;
   logic [4*NREQ-1:0]    req_sel_i;
   logic [32*NREQ-1:0]   req_adr_i;
   logic [32*NREQ-1:0]   req_dat_i;
   logic [NREQ-1:0]      req_ack_o;
   logic [NREQ-1:0]      req_err_o;
   logic [31:0]          req_dat_o;
   logic                 m_cyc_o;
   logic                 m_stb_o;
   logic                 m_we_o;
   logic [3:0]           m_sel_o;
   logic [31:0]          m_adr_o;
   logic [31:0]          m_dat_o;
   logic                 m_ack_i;
   logic [31:0]          m_dat_i;
   logic [NREQ-1:0]      grant_o;
   logic                 timeout_o;

   modport master (
      input  req_cyc_i, req_stb_i, req_we_i, req_sel_i, req_adr_i, req_dat_i,
      input  m_ack_i, m_dat_i,
      output req_ack_o, req_err_o, req_dat_o,
      output m_cyc_o, m_stb_o, m_we_o, m_sel_o, m_adr_o, m_dat_o,
      output grant_o, timeout_o
   );

   modport slave (
      output req_cyc_i, req_stb_i, req_we_i, req_sel_i, req_adr_i, req_dat_i,
      output m_ack_i, m_dat_i,
      input  req_ack_o, req_err_o, req_dat_o,
      input  m_cyc_o, m_stb_o, m_we_o, m_sel_o, m_adr_o, m_dat_o,
      input  grant_o, timeout_o
   );
endinterface

// File: rtl/io_bus_arbiter.sv
// Round-robin Wishbone-classic arbiter for the I/O bridge slave port, with locked
// read-modify-write support and a watchdog that turns hung accesses into error responses.
module io_bus_arbiter #(
   parameter int          NREQ     = 4,
   parameter int          TIMEOUT  = 1023,
   parameter logic [31:0] ERR_DATA = 32'hDEADDEAD
) (
   input  logic               clk_i,
   input  logic               rst_i,
   io_bus_arbiter_if.master   bus,
   output logic [1:0]         state_o
);
   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, BUS, ACK, LOCK} state_e;

   // Handshake: a requester asks for the bus while cyc & stb are high; it owns the result
   // once ack or err rises for its index, and must drop stb to let the arbiter move on.
   state_e            state_q, state_d;
   logic [IW-1:0]     last_q, last_d;
   logic [IW-1:0]     owner_q, owner_d;
   logic [NREQ-1:0]   grant_q, grant_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              m_cyc_q, m_cyc_d, m_stb_q, m_stb_d, m_we_q, m_we_d;
   logic [3:0]        m_sel_q, m_sel_d;
   logic [31:0]       m_adr_q, m_adr_d, m_dat_q, m_dat_d;
   logic [NREQ-1:0]   ack_q, ack_d, err_q, err_d;
   logic [31:0]       rdat_q, rdat_d;
   logic              tmo_q, tmo_d;

   logic [NREQ-1:0]   req_vec;
   logic              win_vld;
   logic [IW-1:0]     win_idx, cand;
   int                j;
   logic              issue;
   logic [IW-1:0]     issue_idx;

   assign req_vec = bus.req_cyc_i & bus.req_stb_i;

   // Rotating search starting just after the previous owner.
   always_comb begin
      win_vld = 1'b0;
      win_idx = '0;
      j       = 0;
      cand    = '0;
      for (int i = 0; i < NREQ; i++) begin
         j    = (int'(last_q) + 1 + i) % NREQ;
         cand = IW'(j);
         if (!win_vld && req_vec[cand]) begin
            win_vld = 1'b1;
            win_idx = cand;
         end
      end
   end

   always_comb begin
      state_d   = state_q;
      last_d    = last_q;
      owner_d   = owner_q;
      grant_d   = grant_q;
      cnt_d     = cnt_q;
      m_cyc_d   = m_cyc_q;
      m_stb_d   = m_stb_q;
      m_we_d    = m_we_q;
      m_sel_d   = m_sel_q;
      m_adr_d   = m_adr_q;
      m_dat_d   = m_dat_q;
      ack_d     = ack_q;
      err_d     = err_q;
      rdat_d    = rdat_q;
      tmo_d     = 1'b0;
      issue     = 1'b0;
      issue_idx = owner_q;

      case (state_q)
         IDLE: begin
            // A stale ack still high from the last access must not leak into a new one.
            if (win_vld && !bus.m_ack_i) begin
               issue     = 1'b1;
               issue_idx = win_idx;
            end
         end
         BUS: begin
            if (cnt_q != {CW{1'b1}}) cnt_d = cnt_q + 1'b1;
            if (bus.m_ack_i || (cnt_q == CW'(TIMEOUT - 1)) || !bus.req_cyc_i[owner_q]) begin
               m_cyc_d = 1'b0;
               m_stb_d = 1'b0;
               m_we_d  = 1'b0;
               m_sel_d = '0;
               m_adr_d = '0;
               m_dat_d = '0;
            end
            if (bus.m_ack_i) begin
               rdat_d  = bus.m_dat_i;
               ack_d   = grant_q;
               state_d = ACK;
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
               rdat_d  = ERR_DATA;
               err_d   = grant_q;
               tmo_d   = 1'b1;
               state_d = ACK;
            end else if (!bus.req_cyc_i[owner_q]) begin
               grant_d = '0;
               last_d  = owner_q;
               state_d = IDLE;
            end
         end
         ACK: begin
            if (!bus.req_stb_i[owner_q]) begin
               ack_d  = '0;
               err_d  = '0;
               rdat_d = '0;
               if (bus.req_cyc_i[owner_q]) begin
                  state_d = LOCK;
               end else begin
                  grant_d = '0;
                  last_d  = owner_q;
                  state_d = IDLE;
               end
            end
         end
         LOCK: begin
            if (!bus.req_cyc_i[owner_q]) begin
               grant_d = '0;
               last_d  = owner_q;
               state_d = IDLE;
            end else if (bus.req_stb_i[owner_q]) begin
               issue = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase

      if (issue) begin
         m_cyc_d = 1'b1;
         m_stb_d = 1'b1;
         m_we_d  = bus.req_we_i[issue_idx];
         m_sel_d = bus.req_sel_i[4*int'(issue_idx) +: 4];
         m_adr_d = bus.req_adr_i[32*int'(issue_idx) +: 32];
         m_dat_d = bus.req_dat_i[32*int'(issue_idx) +: 32];
         owner_d = issue_idx;
         grant_d = NREQ'(1) << issue_idx;
         cnt_d   = '0;
         state_d = BUS;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         last_q  <= IW'(NREQ - 1);
         owner_q <= '0;
         grant_q <= '0;
         cnt_q   <= '0;
         m_cyc_q <= 1'b0;
         m_stb_q <= 1'b0;
         m_we_q  <= 1'b0;
         m_sel_q <= '0;
         m_adr_q <= '0;
         m_dat_q <= '0;
         ack_q   <= '0;
         err_q   <= '0;
         rdat_q  <= '0;
         tmo_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         owner_q <= owner_d;
         grant_q <= grant_d;
         cnt_q   <= cnt_d;
         m_cyc_q <= m_cyc_d;
         m_stb_q <= m_stb_d;
         m_we_q  <= m_we_d;
         m_sel_q <= m_sel_d;
         m_adr_q <= m_adr_d;
         m_dat_q <= m_dat_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
         rdat_q  <= rdat_d;
         tmo_q   <= tmo_d;
      end
   end

   assign bus.req_ack_o = ack_q;
   assign bus.req_err_o = err_q;
   assign bus.req_dat_o = rdat_q;
   assign bus.m_cyc_o   = m_cyc_q;
   assign bus.m_stb_o   = m_stb_q;
   assign bus.m_we_o    = m_we_q;
   assign bus.m_sel_o   = m_sel_q;
   assign bus.m_adr_o   = m_adr_q;
   assign bus.m_dat_o   = m_dat_q;
   assign bus.grant_o   = grant_q;
   assign bus.timeout_o = tmo_q;
   assign state_o       = state_q;
endmodule

// File: tb/tb_io_bus_arbiter.sv
// Directed bench for io_bus_arbiter: a vector table for plain transfers plus hand-written
// sequences for fairness, watchdog, locked RMW, abort/stale ack and mid-access reset.
module tb_io_bus_arbiter;
  localparam int NREQ = 4;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic [1:0] state_o;
  int         n_tests = 0;
  int         n_fail  = 0;

  io_bus_arbiter_if #(.NREQ(NREQ)) bus ();

  io_bus_arbiter #(.NREQ(NREQ), .TIMEOUT(16), .ERR_DATA(32'hDEADDEAD)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .bus     (bus),
    .state_o (state_o)
  );

  // clock / global time limit
  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL sim_time_limit: got timeout expected finish");
    $fatal(1, "time limit");
  end

  typedef struct {
    logic [3:0]  cyc;
    logic [3:0]  stb;
    logic [3:0]  we;
    logic        mack;
    logic [31:0] mdat;
    logic [3:0]  e_grant;
    logic [3:0]  e_ack;
    logic        e_mcyc;
    logic [31:0] e_madr;
    logic [31:0] e_rdat;
  } vec_t;

  vec_t vecs[12];
  logic [3:0] exp_q[$];

  // driver tasks
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic [3:0] cyc, input logic [3:0] stb, input logic [3:0] we);
    bus.req_cyc_i = cyc;
    bus.req_stb_i = stb;
    bus.req_we_i  = we;
  endtask

  task automatic set_m(input logic ack, input logic [31:0] dat);
    bus.m_ack_i = ack;
    bus.m_dat_i = dat;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    drive(4'b0, 4'b0, 4'b0);
    set_m(1'b0, 32'h0);
    rst_i = 1'b1;
    step();
    step();
    rst_i = 1'b0;
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_grant"}, 32'(bus.grant_o), 32'h0);
    chk({name, "_ack"}, 32'(bus.req_ack_o), 32'h0);
    chk({name, "_err"}, 32'(bus.req_err_o), 32'h0);
    chk({name, "_rdat"}, bus.req_dat_o, 32'h0);
    chk({name, "_mbus"}, {bus.m_cyc_o, bus.m_stb_o, bus.m_we_o, bus.m_sel_o, 1'b0, bus.timeout_o},
        32'h0);
    chk({name, "_madr"}, bus.m_adr_o | bus.m_dat_o, 32'h0);
    chk({name, "_state"}, 32'(state_o), 32'h0);
  endtask

  initial begin
    logic [3:0] got;
    logic [3:0] prev_g;
    logic       bad;
    int         cyc_cnt;

    for (int n = 0; n < NREQ; n++) begin
      bus.req_adr_i[32*n +: 32] = 32'hFD0C0000 + 32'(n * 16);
      bus.req_dat_i[32*n +: 32] = 32'hA0000000 + 32'(n);
      bus.req_sel_i[4*n +: 4]   = 4'hF;
    end

    //               cyc      stb      we       ack  mdat          grant    ack      mcyc madr          rdat
    vecs[0]  = '{4'b0010, 4'b0010, 4'b0000, 1'b0, 32'h0,        4'b0010, 4'b0000, 1'b1, 32'hFD0C0010, 32'h0};
    vecs[1]  = '{4'b0010, 4'b0010, 4'b0000, 1'b0, 32'h0,        4'b0010, 4'b0000, 1'b1, 32'hFD0C0010, 32'h0};
    vecs[2]  = '{4'b0010, 4'b0010, 4'b0000, 1'b0, 32'h0,        4'b0010, 4'b0000, 1'b1, 32'hFD0C0010, 32'h0};
    vecs[3]  = '{4'b0010, 4'b0010, 4'b0000, 1'b1, 32'h12345678, 4'b0010, 4'b0010, 1'b0, 32'h0,        32'h12345678};
    vecs[4]  = '{4'b0010, 4'b0010, 4'b0000, 1'b0, 32'h0,        4'b0010, 4'b0010, 1'b0, 32'h0,        32'h12345678};
    vecs[5]  = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 32'h0,        4'b0000, 4'b0000, 1'b0, 32'h0,        32'h0};
    vecs[6]  = '{4'b0110, 4'b0110, 4'b0100, 1'b0, 32'h0,        4'b0100, 4'b0000, 1'b1, 32'hFD0C0020, 32'h0};
    vecs[7]  = '{4'b0110, 4'b0110, 4'b0100, 1'b1, 32'hCAFEF00D, 4'b0100, 4'b0100, 1'b0, 32'h0,        32'hCAFEF00D};
    vecs[8]  = '{4'b0010, 4'b0010, 4'b0000, 1'b0, 32'h0,        4'b0000, 4'b0000, 1'b0, 32'h0,        32'h0};
    vecs[9]  = '{4'b0010, 4'b0010, 4'b0000, 1'b0, 32'h0,        4'b0010, 4'b0000, 1'b1, 32'hFD0C0010, 32'h0};
    vecs[10] = '{4'b0010, 4'b0010, 4'b0000, 1'b1, 32'h5A5A0001, 4'b0010, 4'b0010, 1'b0, 32'h0,        32'h5A5A0001};
    vecs[11] = '{4'b0000, 4'b0000, 4'b0000, 1'b0, 32'h0,        4'b0000, 4'b0000, 1'b0, 32'h0,        32'h0};

    // reset state
    do_reset();
    chk_all_zero("reset");

    // table: single read, write with data broadcast, round-robin after a release
    for (int v = 0; v < 12; v++) begin
      drive(vecs[v].cyc, vecs[v].stb, vecs[v].we);
      set_m(vecs[v].mack, vecs[v].mdat);
      step();
      chk($sformatf("vec%0d_grant", v), 32'(bus.grant_o), 32'(vecs[v].e_grant));
      chk($sformatf("vec%0d_ack", v), 32'(bus.req_ack_o), 32'(vecs[v].e_ack));
      chk($sformatf("vec%0d_err", v), 32'(bus.req_err_o), 32'h0);
      chk($sformatf("vec%0d_mcyc", v), 32'(bus.m_cyc_o), 32'(vecs[v].e_mcyc));
      chk($sformatf("vec%0d_madr", v), bus.m_adr_o, vecs[v].e_madr);
      chk($sformatf("vec%0d_rdat", v), bus.req_dat_o, vecs[v].e_rdat);
    end

    // fairness: req0 and req2 re-request right after each ack, slave acks in one cycle
    do_reset();
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(4'b0001);
      exp_q.push_back(4'b0100);
    end
    prev_g  = 4'b0;
    cyc_cnt = 0;
    while (exp_q.size() > 0 && cyc_cnt < 80) begin
      drive({1'b0, ~bus.req_ack_o[2], 1'b0, ~bus.req_ack_o[0]},
            {1'b0, ~bus.req_ack_o[2], 1'b0, ~bus.req_ack_o[0]}, 4'b0);
      set_m(bus.m_cyc_o, 32'h0);
      step();
      cyc_cnt++;
      got = bus.grant_o;
      if (got != 4'b0 && prev_g == 4'b0) begin
        chk("fair_grant", 32'(got), 32'(exp_q.pop_front()));
      end
      prev_g = got;
    end
    chk("fair_done", 32'(exp_q.size()), 32'h0);

    // watchdog: req3 write never acked
    do_reset();
    drive(4'b1000, 4'b1000, 4'b1000);
    step();
    chk("tmo_grant", 32'(bus.grant_o), 32'h8);
    chk("tmo_issue", {bus.m_cyc_o, bus.m_stb_o, bus.m_we_o, bus.m_sel_o}, 32'h7F);
    chk("tmo_mdat", bus.m_dat_o, 32'hA0000003);
    bad = 1'b0;
    for (int k = 1; k < 16; k++) begin
      step();
      if (bus.m_cyc_o !== 1'b1 || bus.timeout_o !== 1'b0) bad = 1'b1;
    end
    chk("tmo_hold", 32'(bad), 32'h0);
    step();
    chk("tmo_mcyc", 32'(bus.m_cyc_o), 32'h0);
    chk("tmo_err", 32'(bus.req_err_o), 32'h8);
    chk("tmo_ack", 32'(bus.req_ack_o), 32'h0);
    chk("tmo_rdat", bus.req_dat_o, 32'hDEADDEAD);
    chk("tmo_pulse", 32'(bus.timeout_o), 32'h1);
    step();
    chk("tmo_pulse_end", 32'(bus.timeout_o), 32'h0);
    chk("tmo_err_hold", 32'(bus.req_err_o), 32'h8);
    drive(4'b0, 4'b0, 4'b0);
    step();
    chk("tmo_release_err", 32'(bus.req_err_o), 32'h0);
    chk("tmo_release_grant", 32'(bus.grant_o), 32'h0);
    chk("tmo_release_rdat", bus.req_dat_o, 32'h0);

    // locked read-modify-write by req3 while req0 keeps requesting
    do_reset();
    drive(4'b1000, 4'b1000, 4'b0);
    step();
    chk("lock_rd_grant", 32'(bus.grant_o), 32'h8);
    drive(4'b1001, 4'b1001, 4'b0);
    set_m(1'b1, 32'h11112222);
    step();
    chk("lock_rd_ack", 32'(bus.req_ack_o), 32'h8);
    chk("lock_rd_dat", bus.req_dat_o, 32'h11112222);
    drive(4'b1001, 4'b0001, 4'b0);
    set_m(1'b0, 32'h0);
    step();
    chk("lock_enter_grant", 32'(bus.grant_o), 32'h8);
    chk("lock_enter_ack", 32'(bus.req_ack_o), 32'h0);
    step();
    chk("lock_hold_grant", 32'(bus.grant_o), 32'h8);
    chk("lock_hold_mcyc", 32'(bus.m_cyc_o), 32'h0);
    drive(4'b1001, 4'b1001, 4'b1000);
    step();
    chk("lock_wr_issue", {bus.m_cyc_o, bus.m_we_o, bus.grant_o}, 32'h38);
    chk("lock_wr_adr", bus.m_adr_o, 32'hFD0C0030);
    set_m(1'b1, 32'h0);
    step();
    chk("lock_wr_ack", 32'(bus.req_ack_o), 32'h8);
    drive(4'b0001, 4'b0001, 4'b0);
    set_m(1'b0, 32'h0);
    step();
    chk("lock_release", 32'(bus.grant_o), 32'h0);
    step();
    chk("lock_next_grant", 32'(bus.grant_o), 32'h1);
    chk("lock_next_adr", bus.m_adr_o, 32'hFD0C0000);

    // abort, stale-ack block, then ack beating a simultaneous abort
    do_reset();
    drive(4'b0010, 4'b0010, 4'b0);
    step();
    chk("abort_issue", 32'(bus.grant_o), 32'h2);
    step();
    drive(4'b0100, 4'b0100, 4'b0);
    step();
    chk("abort_mcyc", 32'(bus.m_cyc_o), 32'h0);
    chk("abort_grant", 32'(bus.grant_o), 32'h0);
    chk("abort_noresp", 32'(bus.req_ack_o | bus.req_err_o), 32'h0);
    set_m(1'b1, 32'h0);
    step();
    chk("stale_block1", {bus.m_cyc_o, bus.grant_o}, 32'h0);
    step();
    chk("stale_block2", {bus.m_cyc_o, bus.grant_o}, 32'h0);
    set_m(1'b0, 32'h0);
    step();
    chk("stale_clear_grant", 32'(bus.grant_o), 32'h4);
    drive(4'b0, 4'b0, 4'b0);
    set_m(1'b1, 32'h00000077);
    step();
    chk("ack_vs_abort_ack", 32'(bus.req_ack_o), 32'h4);
    chk("ack_vs_abort_dat", bus.req_dat_o, 32'h00000077);
    set_m(1'b0, 32'h0);
    step();
    chk("ack_vs_abort_rel", {bus.req_ack_o, bus.grant_o}, 32'h0);

    // reset in the middle of an access
    do_reset();
    drive(4'b0001, 4'b0001, 4'b0);
    step();
    set_m(1'b1, 32'h0);
    step();
    drive(4'b0, 4'b0, 4'b0);
    set_m(1'b0, 32'h0);
    step();
    drive(4'b0010, 4'b0010, 4'b0);
    step();
    chk("rst_mid_pre", 32'(bus.grant_o), 32'h2);
    rst_i = 1'b1;
    step();
    chk_all_zero("rst_mid");
    rst_i = 1'b0;
    drive(4'b1001, 4'b1001, 4'b0);
    step();
    chk("rst_first_grant", 32'(bus.grant_o), 32'h1);

    // final report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
